// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between icache and dcache.
// One transaction at a time; a RELEASE cycle follows each completion.
module pmem_arbiter #(
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [31:0]       i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [31:0]       d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_I,
    GRANT_D,
    RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic                last_q, last_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                op_q, op_d;

  logic                i_req;
  logic                d_req;
  logic                pick_d;
  logic [31:0]         sel_addr;
  logic                grant;

  assign i_req    = i_pmem_read;
  assign d_req    = d_pmem_read | d_pmem_write;
  // On contention the side that did not win last time goes first.
  assign pick_d   = d_req & (~i_req | ~last_q);
  assign sel_addr = pick_d ? d_pmem_address : i_pmem_address;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req | d_req) begin
          state_d = pick_d ? GRANT_D : GRANT_I;
          last_d  = pick_d;
          addr_d  = {sel_addr[31:5], 5'b0};
          wdata_d = pick_d ? d_pmem_wdata : '0;
          op_d    = pick_d & d_pmem_write;
        end
      end
      GRANT_I: begin
        if (mem_resp) begin
          i_pmem_resp = 1'b1;
          state_d     = RELEASE;
        end
      end
      GRANT_D: begin
        if (mem_resp) begin
          d_pmem_resp = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
    end
  end

  assign grant        = (state_q == GRANT_I) | (state_q == GRANT_D);
  assign mem_read     = grant & ~op_q;
  assign mem_write    = grant & op_q;
  assign mem_address  = addr_q;
  assign mem_wdata    = (state_q == GRANT_D) ? wdata_q : '0;
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter
Interface
REQ-001 Parameter LINE_W, default 256, cache line width in bits for all data buses.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 i_pmem_read  input  1  icache line-fill request.
REQ-005 i_pmem_address  input  32  icache request address.
REQ-006 i_pmem_rdata  output  LINE_W  line data returned to icache.
REQ-007 i_pmem_resp  output  1  one-cycle completion pulse to icache.
REQ-008 d_pmem_read  input  1  dcache line-fill request.
REQ-009 d_pmem_write  input  1  dcache write-back request.
REQ-010 d_pmem_address  input  32  dcache request address.
REQ-011 d_pmem_wdata  input  LINE_W  dcache write-back line.
REQ-012 d_pmem_rdata  output  LINE_W  line data returned to dcache.
REQ-013 d_pmem_resp  output  1  one-cycle completion pulse to dcache.
REQ-014 mem_read  output  1  read command to physical memory.
REQ-015 mem_write  output  1  write command to physical memory.
REQ-016 mem_address  output  32  line-aligned memory address.
REQ-017 mem_wdata  output  LINE_W  memory write data.
REQ-018 mem_rdata  input  LINE_W  memory read data.
REQ-019 mem_resp  input  1  memory completion, valid for one cycle.
Function
REQ-020 FSM states SHALL be IDLE, GRANT_I, GRANT_D, RELEASE; a 1-bit last_grant register (I=0, D=1) SHALL record the most recent grant.
REQ-021 IDLE: no request -> stay; only icache (i_pmem_read) -> GRANT_I; only dcache (d_pmem_read|d_pmem_write) -> GRANT_D; both -> grant side opposite last_grant (round-robin).
REQ-022 On the IDLE->GRANT_x edge SHALL register address with bits [4:0] forced 0, wdata, and op (write = d_pmem_write), and update last_grant.
REQ-023 d_pmem_read and d_pmem_write both high SHALL be treated as a write.
REQ-024 GRANT_x: mem_read/mem_write driven from registered op (exactly one high), mem_address/mem_wdata from registers, all held stable until mem_resp.
REQ-025 mem_resp in GRANT_x: x_pmem_resp=1 same cycle (combinational), other resp 0, next state RELEASE; mem_read/mem_write stay asserted that cycle.
REQ-026 RELEASE: mem_read=mem_write=0, both resps 0, unconditionally -> IDLE next cycle (gives the requester one cycle to drop its request).
REQ-027 Request latency: request seen in IDLE at cycle t -> memory command asserted at t+1; minimum gap between transactions is two idle cycles.
REQ-028 Requester deasserting mid-grant SHALL NOT abort; transaction completes and resp still pulses.
REQ-029 mem_resp in IDLE or RELEASE SHALL be ignored (no resp, no state change).
REQ-030 i_pmem_rdata and d_pmem_rdata SHALL both equal mem_rdata combinationally at all times.
REQ-031 mem_wdata SHALL be 0 during icache grants and all non-grant states.
Reset
REQ-032 rst high SHALL immediately force IDLE, last_grant=I, address/wdata/op registers 0, all outputs except rdata to 0.
REQ-033 rst mid-transaction SHALL abort with no resp pulse; the memory model is reset alongside.
Verification
REQ-034 Reset; i_pmem_read, addr 0x00001004 -> next cycle mem_read=1, mem_address=0x00001000; mem_resp 3 cycles later -> i_pmem_resp 1 cycle, i_pmem_rdata=mem_rdata, RELEASE, IDLE.
REQ-035 After reset, i_pmem_read and d_pmem_write (addr 0x80000040, wdata 0xA5 repeated) same cycle -> dcache granted first, mem_write=1 with wdata; after d resp and RELEASE, icache granted.
REQ-036 Both requesters held continuously for 4 transactions -> grant order D, I, D, I; no resp to non-granted side.
REQ-037 d_pmem_read=d_pmem_write=1 -> mem_write=1, mem_read=0 throughout grant.
REQ-038 rst pulsed during GRANT_D with i_pmem_read pending -> outputs 0 immediately, no d_pmem_resp; after release, dcache silent, icache granted.
REQ-039 mem_resp pulsed in IDLE with no requests -> both resps 0, state stays IDLE.
